// File: rtl/alu_operand_loader.sv
// Operand loader for the 4-bit ALU: gathers A, B and opcode beats with odd parity,
// holds the completed frame with E asserted until the consumer takes it.
module alu_operand_loader #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          CHK_PAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_par,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] op,
  output logic       E,
  input  logic       out_ready,
  output logic       par_err,
  output logic       tmo,
  output logic       err_sticky,
  input  logic       err_clr,
  output logic [7:0] frm_cnt,
  output logic [1:0] dbgState
);

  // Handshake: a beat transfers on a rising edge where din_valid & din_ready,
  // the frame transfers where E & out_ready; neither ready depends on its valid.
  typedef enum logic [1:0] {LD_A = 2'd0, LD_B = 2'd1, LD_OP = 2'd2, PRESENT = 2'd3} stateT;

  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

  stateT      state, stateNext;
  logic [7:0] idleCnt, idleNext;
  logic [8:0] idleInc;
  logic       parOk, beatFire, beatGood, parBad, timeoutHit, frameTake;

  assign din_ready = (state != PRESENT);
  assign E         = (state == PRESENT);
  assign dbgState  = state;

  always_comb begin
    parOk      = (^{din, din_par}) | ~CHK_PAR;
    beatFire   = din_valid & din_ready;
    beatGood   = beatFire & parOk;
    parBad     = beatFire & ~parOk;
    frameTake  = E & out_ready;
    idleInc    = {1'b0, idleCnt} + 9'd1;
    idleNext   = 8'd0;
    timeoutHit = 1'b0;
    // Only a partial frame waiting on its next beat can stall out.
    if ((state == LD_B || state == LD_OP) && !beatFire) begin
      if (idleInc >= TMO_LIM) timeoutHit = 1'b1;
      else                    idleNext   = idleInc[7:0];
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      LD_A:    if (parBad) stateNext = LD_A;
               else if (beatGood) stateNext = LD_B;
      LD_B:    if (parBad || timeoutHit) stateNext = LD_A;
               else if (beatGood) stateNext = LD_OP;
      LD_OP:   if (parBad || timeoutHit) stateNext = LD_A;
               else if (beatGood) stateNext = PRESENT;
      PRESENT: if (frameTake) stateNext = LD_A;
      default: stateNext = LD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_A;
      idleCnt    <= 8'd0;
      a          <= 4'd0;
      b          <= 4'd0;
      op         <= 4'd0;
      par_err    <= 1'b0;
      tmo        <= 1'b0;
      err_sticky <= 1'b0;
      frm_cnt    <= 8'd0;
    end else begin
      state   <= stateNext;
      idleCnt <= idleNext;
      par_err <= parBad;
      tmo     <= timeoutHit;
      if (beatGood) begin
        case (state)
          LD_A:    a  <= din;
          LD_B:    b  <= din;
          LD_OP:   op <= din;
          default: ;
        endcase
      end
      // A new error outranks a simultaneous clear.
      if (parBad || timeoutHit) err_sticky <= 1'b1;
      else if (err_clr)         err_sticky <= 1'b0;
      if (frameTake) frm_cnt <= frm_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios then random traffic, every cycle
// compared against a beat-queue reference model.
module tb_alu_operand_loader;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'd0;
  logic       din_par = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [3:0] a, b, op;
  logic       E;
  logic       out_ready = 1'b0;
  logic       par_err, tmo, err_sticky;
  logic       err_clr = 1'b0;
  logic [7:0] frm_cnt;
  logic [1:0] dbgState;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [3:0] beats[$];
  bit         mPres;
  int         mIdle;
  logic [3:0] mA, mB, mOp;
  logic       mPe, mTo, mSticky;
  logic [7:0] mFrm;

  alu_operand_loader #(.TIMEOUT(TMO), .CHK_PAR(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_par(din_par), .din_valid(din_valid),
    .din_ready(din_ready), .a(a), .b(b), .op(op), .E(E), .out_ready(out_ready),
    .par_err(par_err), .tmo(tmo), .err_sticky(err_sticky), .err_clr(err_clr),
    .frm_cnt(frm_cnt), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  function automatic logic goodPar(input logic [3:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] d, input logic p,
                           input logic v, input logic o, input logic c);
    logic pe, to;
    pe = 1'b0;
    to = 1'b0;
    if (r) begin
      beats.delete();
      mPres = 0; mIdle = 0; mA = 0; mB = 0; mOp = 0;
      mPe = 0; mTo = 0; mSticky = 0; mFrm = 0;
    end else begin
      if (!mPres) begin
        if (v) begin
          mIdle = 0;
          if (($countones(d) + p) % 2 == 1) begin
            beats.push_back(d);
            case (beats.size())
              1: mA = d;
              2: mB = d;
              default: begin mOp = d; mPres = 1; beats.delete(); end
            endcase
          end else begin
            pe = 1'b1;
            beats.delete();
          end
        end else if (beats.size() > 0) begin
          mIdle++;
          if (mIdle == TMO) begin
            to = 1'b1;
            beats.delete();
            mIdle = 0;
          end
        end
      end else if (o) begin
        mPres = 0;
        mFrm = mFrm + 8'd1;
      end
      if (pe || to) mSticky = 1'b1;
      else if (c)   mSticky = 1'b0;
      mPe = pe;
      mTo = to;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chkModel();
    chk("din_ready", {7'd0, din_ready}, {7'd0, !mPres});
    chk("E", {7'd0, E}, {7'd0, mPres});
    chk("a", {4'd0, a}, {4'd0, mA});
    chk("b", {4'd0, b}, {4'd0, mB});
    chk("op", {4'd0, op}, {4'd0, mOp});
    chk("par_err", {7'd0, par_err}, {7'd0, mPe});
    chk("tmo", {7'd0, tmo}, {7'd0, mTo});
    chk("err_sticky", {7'd0, err_sticky}, {7'd0, mSticky});
    chk("frm_cnt", frm_cnt, mFrm);
  endtask

  task automatic cyc(input logic r, input logic [3:0] d, input logic p,
                     input logic v, input logic o, input logic c);
    rst = r; din = d; din_par = p; din_valid = v; out_ready = o; err_clr = c;
    @(posedge clk);
    modelStep(r, d, p, v, o, c);
    #1;
    chkModel();
  endtask

  task automatic beat(input logic [3:0] d, input bit bad, input logic o);
    logic gp;
    gp = goodPar(d);
    cyc(1'b0, d, bad ? ~gp : gp, 1'b1, o, 1'b0);
  endtask

  task automatic idle(input int n, input logic o);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, o, 1'b0);
  endtask

  initial begin
    // reset
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_E", {7'd0, E}, 8'd0);
    chk("rst_ready", {7'd0, din_ready}, 8'd1);
    chk("rst_frm", frm_cnt, 8'd0);

    // basic frame held while consumer stalls
    beat(4'h3, 0, 1'b0);
    beat(4'h5, 0, 1'b0);
    chk("pre_E", {7'd0, E}, 8'd0);
    beat(4'hA, 0, 1'b0);
    chk("pres_E", {7'd0, E}, 8'd1);
    idle(10, 1'b0);
    chk("hold_a", {4'd0, a}, 8'h3);
    chk("hold_b", {4'd0, b}, 8'h5);
    chk("hold_op", {4'd0, op}, 8'hA);
    chk("hold_ready", {7'd0, din_ready}, 8'd0);
    idle(1, 1'b1);
    chk("rel_E", {7'd0, E}, 8'd0);
    chk("rel_frm", frm_cnt, 8'd1);
    chk("rel_a", {4'd0, a}, 8'h3);

    // bad parity on B beat, then clear and a clean frame
    beat(4'h2, 0, 1'b0);
    beat(4'h6, 1, 1'b0);
    chk("perr_pulse", {7'd0, par_err}, 8'd1);
    chk("perr_sticky", {7'd0, err_sticky}, 8'd1);
    chk("perr_b_kept", {4'd0, b}, 8'h5);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_sticky", {7'd0, err_sticky}, 8'd0);
    beat(4'h9, 1, 1'b0);
    chk("perr_lda", {7'd0, par_err}, 8'd1);
    beat(4'h1, 0, 1'b0);
    beat(4'h2, 0, 1'b0);
    beat(4'h3, 0, 1'b0);
    chk("frame2_op", {4'd0, op}, 8'h3);
    idle(1, 1'b1);

    // timeout after A, and beat landing exactly on the limit
    beat(4'h7, 0, 1'b0);
    idle(3, 1'b0);
    chk("tmo_early", {7'd0, tmo}, 8'd0);
    idle(1, 1'b0);
    chk("tmo_pulse", {7'd0, tmo}, 8'd1);
    chk("tmo_ready", {7'd0, din_ready}, 8'd1);
    idle(3, 1'b0);
    chk("tmo_noE", {7'd0, E}, 8'd0);
    beat(4'h4, 0, 1'b0);
    idle(3, 1'b0);
    beat(4'h8, 0, 1'b0);
    chk("edge_notmo", {7'd0, tmo}, 8'd0);
    beat(4'hC, 0, 1'b0);
    chk("edge_E", {7'd0, E}, 8'd1);
    // set beats clear in the same cycle
    idle(1, 1'b1);
    beat(4'h1, 1, 1'b0);
    cyc(1'b0, 4'h2, ~goodPar(4'h2), 1'b1, 1'b0, 1'b1);
    chk("set_wins", {7'd0, err_sticky}, 8'd1);

    // 256 back-to-back frames wrap the counter
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      beat(4'($urandom_range(0, 15)), 0, 1'b1);
      beat(4'($urandom_range(0, 15)), 0, 1'b1);
      beat(4'($urandom_range(0, 15)), 0, 1'b1);
      idle(1, 1'b1);
    end
    chk("wrap_frm", frm_cnt, 8'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 199) == 0), d,
          ($urandom_range(0, 7) == 0) ? ~goodPar(d) : goodPar(d),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0));
    end

    // reset while presenting
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'hE, 0, 1'b0);
    beat(4'hD, 0, 1'b0);
    beat(4'hB, 0, 1'b0);
    idle(1, 1'b1);
    beat(4'h6, 0, 1'b0);
    beat(4'h5, 0, 1'b0);
    beat(4'h4, 0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prst_E", {7'd0, E}, 8'd0);
    chk("prst_a", {4'd0, a}, 8'd0);
    chk("prst_b", {4'd0, b}, 8'd0);
    chk("prst_op", {4'd0, op}, 8'd0);
    chk("prst_frm", frm_cnt, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
